// File: rtl/pwm_fade_scheduler_pkg.sv
// rtl/pwm_fade_scheduler_pkg.sv - shared widths, sequencer states and fade step helper
// Contents: PWM_DUTY_W, DEFAULT_FADE_TICKS, duty_t, seq_state_e, fade_step().
package pwm_fade_scheduler_pkg;

  localparam int PWM_DUTY_W         = 8;
  localparam int DEFAULT_FADE_TICKS = 30000;

  typedef logic [PWM_DUTY_W-1:0] duty_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE_A = 3'd2,
    ST_STROBE_B = 3'd3,
    ST_RELEASE  = 3'd4
  } seq_state_e;

  // One fade step from cur toward tgt. The extra bit keeps 250+10 and 3-10
  // from wrapping, so the result clamps at tgt instead of overshooting.
  function automatic duty_t fade_step(input duty_t cur, input duty_t tgt, input duty_t step);
    logic [PWM_DUTY_W:0] up;
    logic [PWM_DUTY_W:0] down;
    up   = {1'b0, cur} + {1'b0, step};
    down = {1'b0, cur} - {1'b0, step};
    if (tgt > cur) begin
      fade_step = (up > {1'b0, tgt}) ? tgt : up[PWM_DUTY_W-1:0];
    end else begin
      fade_step = (down[PWM_DUTY_W] || (down[PWM_DUTY_W-1:0] < tgt)) ? tgt : down[PWM_DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pwm_fade_scheduler_rr_picker.sv
// rtl/pwm_fade_scheduler_rr_picker.sv - combinational round-robin request picker
// Ports: req (request vector), last (previous grant), grant (next index after
// last with req set, wrapping), any (at least one request).
module pwm_fade_scheduler_rr_picker #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] grant,
  output logic          any
);

  logic [CW-1:0] idx;
  logic          found;

  // Scan last+1, last+2, ... last+N; the first hit wins, so last itself is
  // only chosen when it is the sole requester.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = CW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pwm_fade_scheduler.sv
// rtl/pwm_fade_scheduler.sv - fades per-channel pwm duties and sequences their load strobes
// Ports: masterClk, reset (async, active high); wrEn/wrChannel/wrData/wrImmediate
// target write port; controlOut shared duty bus; loadOut per-channel load strobe;
// fading (any cur != tgt); busy (sequencer active or a channel awaiting delivery).
module pwm_fade_scheduler
  import pwm_fade_scheduler_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int FADE_TICKS = DEFAULT_FADE_TICKS,
  parameter int FADE_STEP  = 1
) (
  input  logic                        masterClk,
  input  logic                        reset,
  input  logic                        wrEn,
  input  logic [$clog2(CHANNELS)-1:0] wrChannel,
  input  logic [PWM_DUTY_W-1:0]       wrData,
  input  logic                        wrImmediate,
  output logic [PWM_DUTY_W-1:0]       controlOut,
  output logic [CHANNELS-1:0]         loadOut,
  output logic                        fading,
  output logic                        busy
);

  localparam int CW = $clog2(CHANNELS);
  localparam int TW = $clog2(FADE_TICKS);
  localparam duty_t STEP = duty_t'(FADE_STEP);
  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

  duty_t               cur [CHANNELS];
  duty_t               tgt [CHANNELS];
  logic [CHANNELS-1:0] dirty;
  logic [CHANNELS-1:0] wrHit;
  logic [CHANNELS-1:0] stepHit;
  logic [TW-1:0]       tickCount;
  logic                tick;
  logic                anyDiff;

  seq_state_e          state;
  logic [CW-1:0]       sel;
  logic [CW-1:0]       lastServed;
  logic [CW-1:0]       grant;
  logic                anyDirty;

  assign tick = (tickCount == TW'(FADE_TICKS - 1));

  // A write to a channel shadows a same-cycle tick on that channel.
  // Out-of-range wrChannel values match no channel and are dropped.
  always_comb begin
    wrHit   = '0;
    stepHit = '0;
    anyDiff = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrHit[i]   = wrEn && (wrChannel == CW'(i));
      stepHit[i] = tick && (cur[i] != tgt[i]) && !wrHit[i];
      anyDiff    = anyDiff | (cur[i] != tgt[i]);
    end
  end

  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
      dirty     <= '0;
      tickCount <= '0;
      fading    <= 1'b0;
    end else begin
      tickCount <= tick ? '0 : tickCount + TW'(1);
      fading    <= anyDiff;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrHit[i]) begin
          tgt[i] <= wrData;
          if (wrImmediate) cur[i] <= wrData;
        end else if (stepHit[i]) begin
          cur[i] <= fade_step(cur[i], tgt[i], STEP);
        end
        // Set beats the SETUP clear so a value changed during capture is re-served.
        if ((wrHit[i] && wrImmediate) || stepHit[i]) begin
          dirty[i] <= 1'b1;
        end else if ((state == ST_SETUP) && (sel == CW'(i))) begin
          dirty[i] <= 1'b0;
        end
      end
    end
  end

  pwm_fade_scheduler_rr_picker #(
    .N  (CHANNELS),
    .CW (CW)
  ) rr_picker (
    .req   (dirty),
    .last  (lastServed),
    .grant (grant),
    .any   (anyDirty)
  );

  // controlOut is captured in SETUP and held until after RELEASE, so it is
  // settled a full cycle before the load edge and through the whole strobe.
  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= '0;
      lastServed <= CW'(CHANNELS - 1);
      controlOut <= '0;
      loadOut    <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE) || (|dirty);
      case (state)
        ST_IDLE: begin
          if (anyDirty) begin
            sel   <= grant;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          controlOut <= cur[sel];
          loadOut    <= '0;
          state      <= ST_STROBE_A;
        end
        ST_STROBE_A: begin
          loadOut <= ONE << sel;
          state   <= ST_STROBE_B;
        end
        ST_STROBE_B: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          loadOut    <= '0;
          lastServed <= sel;
          state      <= ST_IDLE;
        end
        default: begin
          loadOut <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// tb/tb_pwm_fade_scheduler.sv - scoreboard bench for pwm_fade_scheduler
module tb_pwm_fade_scheduler;

  localparam int CHANNELS = 8;
  localparam int CW       = 3;

  logic                masterClk = 1'b0;
  logic                reset = 1'b1;
  logic                wrEn = 1'b0;
  logic [CW-1:0]       wrChannel = '0;
  logic [7:0]          wrData = '0;
  logic                wrImmediate = 1'b0;
  logic [7:0]          controlOut, controlOutSat;
  logic [CHANNELS-1:0] loadOut, loadOutSat;
  logic                fading, fadingSat, busy, busySat;

  typedef struct {
    int         ch;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [7:0] expVal;
    int         expLat;
  } vec_t;

  exp_t expq[$];
  exp_t satq[$];
  vec_t vecs[4];
  int   checks = 0;
  int   failures = 0;

  always #5 masterClk = ~masterClk;

  pwm_fade_scheduler #(.CHANNELS(CHANNELS), .FADE_TICKS(40), .FADE_STEP(2)) dut (
    .masterClk   (masterClk),
    .reset       (reset),
    .wrEn        (wrEn),
    .wrChannel   (wrChannel),
    .wrData      (wrData),
    .wrImmediate (wrImmediate),
    .controlOut  (controlOut),
    .loadOut     (loadOut),
    .fading      (fading),
    .busy        (busy)
  );

  pwm_fade_scheduler #(.CHANNELS(CHANNELS), .FADE_TICKS(40), .FADE_STEP(10)) dutSat (
    .masterClk   (masterClk),
    .reset       (reset),
    .wrEn        (wrEn),
    .wrChannel   (wrChannel),
    .wrData      (wrData),
    .wrImmediate (wrImmediate),
    .controlOut  (controlOutSat),
    .loadOut     (loadOutSat),
    .fading      (fadingSat),
    .busy        (busySat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] get_ctl(input bit inst);
    return inst ? controlOutSat : controlOut;
  endfunction

  function automatic logic [CHANNELS-1:0] get_ld(input bit inst);
    return inst ? loadOutSat : loadOut;
  endfunction

  task automatic push_exp(input bit inst, input int ch, input logic [7:0] val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    if (inst) satq.push_back(e);
    else expq.push_back(e);
  endtask

  task automatic drive_write(input int ch, input logic [7:0] data, input bit imm);
    @(negedge masterClk);
    wrEn        = 1'b1;
    wrChannel   = CW'(ch);
    wrData      = data;
    wrImmediate = imm;
    @(negedge masterClk);
    wrEn        = 1'b0;
    wrImmediate = 1'b0;
  endtask

  // Waits for the next load strobe of one instance, compares it with the head
  // of that instance's expected queue, then follows it until it falls.
  task automatic wait_strobe(input string name, input bit inst, input int budget, input int expLat);
    int                  n;
    int                  width;
    int                  ch;
    bit                  stable;
    logic [7:0]          prev;
    logic [7:0]          val;
    logic [CHANNELS-1:0] ld;
    exp_t                e;
    n    = 0;
    prev = get_ctl(inst);
    forever begin
      @(negedge masterClk);
      n++;
      if (get_ld(inst) != '0 || n >= budget) break;
      prev = get_ctl(inst);
    end
    ld = get_ld(inst);
    if (ld == '0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no strobe in %0d cycles required=strobe", name, n);
      if (inst && satq.size() > 0) void'(satq.pop_front());
      if (!inst && expq.size() > 0) void'(expq.pop_front());
      return;
    end
    val = get_ctl(inst);
    ch  = -1;
    for (int i = 0; i < CHANNELS; i++) if (ld[i]) ch = i;
    check({name, "_onehot"}, 32'($onehot(ld)), 1);
    if ((inst ? satq.size() : expq.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected actual=strobe ch%0d val=%0d required=none", name, ch, val);
    end else begin
      e = inst ? satq.pop_front() : expq.pop_front();
      check({name, "_ch"}, ch, e.ch);
      check({name, "_val"}, val, e.val);
    end
    check({name, "_presetup"}, prev, val);
    if (expLat >= 0) check({name, "_latency"}, n, expLat);
    width  = 0;
    stable = 1'b1;
    while (get_ld(inst) == ld && width < 10) begin
      width++;
      if (get_ctl(inst) != val) stable = 1'b0;
      @(negedge masterClk);
    end
    check({name, "_width"}, width, 2);
    check({name, "_stable"}, 32'(stable), 1);
  endtask

  initial begin
    int act;
    int n;

    vecs[0] = '{ch: 2, data: 8'h80, expVal: 8'h80, expLat: 3};
    vecs[1] = '{ch: 0, data: 8'h00, expVal: 8'h00, expLat: 3};
    vecs[2] = '{ch: 7, data: 8'hFF, expVal: 8'hFF, expLat: 3};
    vecs[3] = '{ch: 3, data: 8'h5A, expVal: 8'h5A, expLat: 3};

    repeat (3) @(negedge masterClk);
    check("rst_controlOut", controlOut, 0);
    check("rst_loadOut", loadOut, 0);
    check("rst_fading", fading, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge masterClk);

    for (int v = 0; v < 4; v++) begin
      push_exp(0, vecs[v].ch, vecs[v].expVal);
      drive_write(vecs[v].ch, vecs[v].data, 1'b1);
      wait_strobe($sformatf("vec%0d", v), 0, 20, vecs[v].expLat);
      @(negedge masterClk);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Back-to-back immediate writes: served 1, 5, 6 with 5-cycle spacing.
    push_exp(0, 1, 8'h11);
    push_exp(0, 5, 8'h55);
    push_exp(0, 6, 8'h66);
    @(negedge masterClk);
    wrEn = 1'b1; wrImmediate = 1'b1; wrChannel = 3'd1; wrData = 8'h11;
    @(negedge masterClk);
    wrChannel = 3'd5; wrData = 8'h55;
    @(negedge masterClk);
    wrChannel = 3'd6; wrData = 8'h66;
    @(negedge masterClk);
    wrEn = 1'b0; wrImmediate = 1'b0;
    wait_strobe("rr1", 0, 20, 1);
    wait_strobe("rr5", 0, 20, 3);
    wait_strobe("rr6", 0, 20, 3);

    // Ramp ch0 0 -> 5 in steps of 2, one tick every 40 cycles.
    push_exp(0, 0, 8'd2);
    push_exp(0, 0, 8'd4);
    push_exp(0, 0, 8'd5);
    drive_write(0, 8'd5, 1'b0);
    wait_strobe("ramp2", 0, 100, -1);
    check("ramp_fading_mid", fading, 1);
    wait_strobe("ramp4", 0, 100, 38);
    wait_strobe("ramp5", 0, 100, 38);
    check("ramp_fading_end", fading, 0);
    @(negedge masterClk);
    check("ramp_busy_end", busy, 0);

    // Second write to ch3 lands in its SETUP cycle.
    push_exp(0, 3, 8'h11);
    push_exp(0, 3, 8'h22);
    @(negedge masterClk);
    wrEn = 1'b1; wrImmediate = 1'b1; wrChannel = 3'd3; wrData = 8'h11;
    @(negedge masterClk);
    wrEn = 1'b0; wrImmediate = 1'b0;
    @(negedge masterClk);
    wrEn = 1'b1; wrImmediate = 1'b1; wrChannel = 3'd3; wrData = 8'h22;
    @(negedge masterClk);
    wrEn = 1'b0; wrImmediate = 1'b0;
    wait_strobe("coll_old", 0, 20, 1);
    wait_strobe("coll_new", 0, 20, 3);
    @(negedge masterClk);
    check("coll_busy_end", busy, 0);

    // Reset while the strobe is high.
    drive_write(6, 8'h33, 1'b1);
    n = 0;
    while (loadOut == '0 && n < 10) begin
      @(negedge masterClk);
      n++;
    end
    check("rms_strobe_seen", loadOut, 32'h40);
    #1 reset = 1'b1;
    #1;
    check("rms_load_async", loadOut, 0);
    check("rms_ctl_async", controlOut, 0);
    @(negedge masterClk);
    reset = 1'b0;
    act = 0;
    repeat (60) begin
      @(negedge masterClk);
      if (loadOut != '0) act++;
    end
    check("rms_quiet", act, 0);
    check("rms_busy", busy, 0);
    push_exp(0, 6, 8'h44);
    drive_write(6, 8'h44, 1'b1);
    wait_strobe("rms_after", 0, 20, 3);

    // Saturation on the step-10 instance: 250 toward 255 lands on 255.
    push_exp(1, 4, 8'd250);
    drive_write(4, 8'd250, 1'b1);
    wait_strobe("sat_imm", 1, 20, 3);
    push_exp(1, 4, 8'd255);
    drive_write(4, 8'd255, 1'b0);
    wait_strobe("sat_ramp", 1, 100, -1);
    act = 0;
    repeat (60) begin
      @(negedge masterClk);
      if (loadOutSat != '0) act++;
    end
    check("sat_quiet", act, 0);
    check("sat_fading", fadingSat, 0);
    check("sat_busy", busySat, 0);

    check("queues_drained", expq.size() + satq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
